// File: rtl/icache_axi_rd_bridge.sv
// icache_axi_rd_bridge
// Takes one instruction-cache refill request at a time and turns it into a
// single AXI4 INCR read burst. The 32-bit R beats are returned to the cache
// in order, one cycle after each R handshake.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no request in flight, waiting for addr_valid_i
// AR     | arvalid_o held high with the latched address/length
// DATA   | rready_o high, forwarding beats until the rlast handshake
//
// The drop flag records a flush of the request in flight. Once it is set,
// the remaining beats are still drained from AXI but are not forwarded.
// The beat counter is 9 bits wide and saturates, so a slave that returns
// far more beats than requested cannot wrap it back into the forwarding
// range.

module icache_axi_rd_bridge #(
  parameter int                  ID_WIDTH = 4,
  parameter logic [ID_WIDTH-1:0] AXI_ID   = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  input  logic                addr_valid_i,
  input  logic [31:0]         addr_i,
  input  logic [7:0]          data_len_i,
  output logic                resp_ready_o,
  output logic                data_valid_o,
  output logic [31:0]         data_o,
  output logic                busy_o,
  output logic                err_o,
  output logic [ID_WIDTH-1:0] arid_o,
  output logic [31:0]         araddr_o,
  output logic [7:0]          arlen_o,
  output logic [2:0]          arsize_o,
  output logic [1:0]          arburst_o,
  output logic                arvalid_o,
  input  logic                arready_i,
  input  logic [ID_WIDTH-1:0] rid_i,
  input  logic [31:0]         rdata_i,
  input  logic [1:0]          rresp_i,
  input  logic                rlast_i,
  input  logic                rvalid_i,
  output logic                rready_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_DATA = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  arlen_q, arlen_d;
  logic        arvalid_q, arvalid_d;
  logic [8:0]  cnt_q, cnt_d;
  logic        drop_q, drop_d;
  logic        err_q, err_d;
  logic        resp_q, resp_d;
  logic        dv_q, dv_d;
  logic [31:0] data_q, data_d;

  logic        drop_now;
  logic        ar_hs;
  logic        r_hs;
  logic        beat_in_range;
  logic        last_mismatch;

  // Only one burst is ever outstanding, so the returned ID carries no
  // information.
  logic unused_rid;
  assign unused_rid = ^rid_i;

  // A flush in the current cycle takes effect on the beat or handshake that
  // happens in that same cycle.
  assign drop_now      = drop_q | flush_i;
  assign ar_hs         = arvalid_q & arready_i;
  assign r_hs          = (state_q == S_DATA) & rvalid_i;
  assign beat_in_range = cnt_q < {1'b0, len_q};
  assign last_mismatch = rlast_i & ((cnt_q + 9'd1) != {1'b0, len_q});

  // State register and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      arlen_q   <= '0;
      arvalid_q <= 1'b0;
      cnt_q     <= '0;
      drop_q    <= 1'b0;
      err_q     <= 1'b0;
      resp_q    <= 1'b0;
      dv_q      <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      arlen_q   <= arlen_d;
      arvalid_q <= arvalid_d;
      cnt_q     <= cnt_d;
      drop_q    <= drop_d;
      err_q     <= err_d;
      resp_q    <= resp_d;
      dv_q      <= dv_d;
      data_q    <= data_d;
    end
  end

  // Next-state logic: request acceptance, AR handshake, beat forwarding,
  // error detection.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    arlen_d   = arlen_q;
    arvalid_d = arvalid_q;
    cnt_d     = cnt_q;
    drop_d    = drop_q;
    err_d     = err_q;
    resp_d    = 1'b0;
    dv_d      = 1'b0;
    data_d    = data_q;

    case (state_q)
      S_IDLE: begin
        drop_d = 1'b0;
        if (addr_valid_i && (data_len_i != 8'd0) && !flush_i) begin
          state_d   = S_AR;
          addr_d    = addr_i;
          len_d     = data_len_i;
          arlen_d   = data_len_i - 8'd1;
          arvalid_d = 1'b1;
          err_d     = 1'b0;
        end
      end

      S_AR: begin
        // arvalid must not be withdrawn once raised, so a flush here only
        // marks the burst to be dropped.
        drop_d = drop_now;
        if (ar_hs) begin
          state_d   = S_DATA;
          arvalid_d = 1'b0;
          cnt_d     = '0;
          resp_d    = ~drop_now;
        end
      end

      S_DATA: begin
        drop_d = drop_now;
        if (r_hs) begin
          data_d = rdata_i;
          dv_d   = ~drop_now & beat_in_range;
          if ((rresp_i != 2'b00) || !beat_in_range || last_mismatch) begin
            err_d = 1'b1;
          end
          if (cnt_q != 9'h1FF) begin
            cnt_d = cnt_q + 9'd1;
          end
          if (rlast_i) begin
            state_d = S_IDLE;
            drop_d  = 1'b0;
          end
        end
      end

      default: begin
        state_d   = S_IDLE;
        arvalid_d = 1'b0;
        drop_d    = 1'b0;
      end
    endcase
  end

  // The acceptance pulse is registered but is also masked by a flush that
  // arrives in the very cycle it is shown.
  assign resp_ready_o = resp_q & ~flush_i;
  assign data_valid_o = dv_q;
  assign data_o       = data_q;
  assign busy_o       = (state_q != S_IDLE);
  assign err_o        = err_q;

  assign arid_o    = AXI_ID;
  assign araddr_o  = addr_q;
  assign arlen_o   = arlen_q;
  assign arsize_o  = 3'b010;
  assign arburst_o = 2'b01;
  assign arvalid_o = arvalid_q;
  assign rready_o  = (state_q == S_DATA);

endmodule

// File: doc/icache_axi_rd_bridge.md
Name: icache_axi_rd_bridge

Overview:
- Responder side of the instruction-cache refill request interface: addr_valid/addr/data_len in, resp_ready, data_valid and data out.
- Accepts one request at a time and converts it into a single AXI4 INCR read burst (AR/R channels).
- Streams the returned 32-bit beats back to the cache in order.
- Sits between the icache and the top-level AXI arbiter/crossbar.

Parameters:
- AXI_ID, 4'd0, constant value driven on arid_o.
- ID_WIDTH, 4, width of the AXI ID fields.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- flush_i  in  1  discard the request in flight; no further resp_ready/data_valid for it.
- addr_valid_i  in  1  request strobe; may be a single-cycle pulse.
- addr_i  in  32  physical byte address, word aligned.
- data_len_i  in  8  number of 32-bit beats, 0..255.
- resp_ready_o  out  1  one-cycle pulse: request accepted by AXI.
- data_valid_o  out  1  one beat valid on data_o.
- data_o  out  32  returned beat.
- busy_o  out  1  state != IDLE.
- err_o  out  1  sticky: non-OKAY rresp or burst-length mismatch; cleared on the next accepted request.
- arid_o  out  ID_WIDTH  AR channel ID.
- araddr_o  out  32  AR channel address.
- arlen_o  out  8  AR burst length minus one.
- arsize_o  out  3  AR beat size.
- arburst_o  out  2  AR burst type.
- arvalid_o  out  1  AR valid.
- arready_i  in  1  AR ready.
- rid_i  in  ID_WIDTH  R channel ID, ignored.
- rdata_i  in  32  R data.
- rresp_i  in  2  R response.
- rlast_i  in  1  R last beat.
- rvalid_i  in  1  R valid.
- rready_o  out  1  R ready.

Behaviour:
- Reset (async): state IDLE; every output 0 except the constants arid_o=AXI_ID, arsize_o=3'b010, arburst_o=2'b01. Beat counter, drop flag and err_o are cleared.
- States: IDLE, AR, DATA.
- IDLE:
  - addr_valid_i=1, data_len_i!=0, flush_i=0: latch addr and len, clear err_o and the drop flag, go to AR.
  - data_len_i=0, or flush_i=1 in the same cycle: request ignored, stay IDLE, no pulses.
  - addr_valid_i in any state other than IDLE is ignored. The cache never issues a request while busy.
- AR:
  - arvalid_o=1, araddr_o=latched addr, arlen_o=len-1. All three are registers, held stable until arready_i.
  - On arvalid_o and arready_i: go to DATA and reset the beat count to 0.
  - resp_ready_o is registered: it is 1 in the cycle after the AR handshake, for exactly 1 cycle, unless the drop flag is set.
- DATA:
  - rready_o=1. The cache applies no backpressure.
  - Each R handshake increments the beat count.
  - data_o and data_valid_o are registered: the beat appears 1 cycle after its R handshake.
  - data_valid_o is suppressed when the drop flag is set or count >= len.
  - Return to IDLE on the handshake with rlast_i=1.
- Timing guarantee: the earliest R beat is at T+1 after AR handshake cycle T, so the earliest data_valid_o is T+2. resp_ready_o (T+1) therefore always strictly precedes the first data_valid_o.
- Errors (err_o set; the beat is still forwarded if otherwise allowed):
  - rresp_i != 2'b00 on any beat.
  - rlast_i on a beat whose count+1 != len.
  - More than len beats: extra beats are accepted (rready stays 1), not forwarded, and err_o is set.
  - Fewer than len beats (early rlast_i): go to IDLE anyway.
- flush_i:
  - In AR: set the drop flag; arvalid_o stays asserted until the handshake (AXI forbids withdrawing it); the resp_ready_o pulse is suppressed.
  - In DATA: set the drop flag; remaining beats are drained with rready_o=1, and data_valid_o is 0 from the next cycle on.
  - In the cycle resp_ready_o would pulse: the pulse is suppressed.
  - The drop flag clears on return to IDLE.
- Only one transaction is outstanding; rid_i is ignored.
- Reset mid-burst forces IDLE immediately. The AXI slave is reset on the same reset net, so no drain is done.
- busy_o is combinational from state.

Test Plan:
- 8-beat refill: addr_i=0x1C000040, len=8, arready 2 cycles late.
  - AR: araddr=0x1C000040, arlen=7, arsize=2, arburst=1.
  - resp_ready_o pulses once at T+1.
  - R data 0xA0..0xA7 back-to-back with rlast on the 8th beat: data_valid_o high for 8 consecutive cycles starting T+2, data_o=0xA0..0xA7, then busy_o=0.
- Uncached 1-beat fetch: len=1, rvalid gapped by 3 idle cycles.
  - arlen=0; resp_ready_o pulse; a single data_valid_o with the beat; err_o=0.
- Zero length and busy: len=0 pulse gives no arvalid and busy_o=0. A second addr_valid_i while in DATA is ignored; still one AR per first request.
- Response error: beat 3 of 4 has rresp=2'b10.
  - All 4 beats forwarded; err_o=1 from the cycle after beat 3.
  - err_o cleared by the next accepted request.
- Flush in AR: flush_i while arvalid_o=1 and arready_i=0.
  - arvalid_o stays high until arready_i.
  - No resp_ready_o pulse; all 8 beats drained with data_valid_o=0; IDLE after rlast.
- Length mismatch and reset:
  - rlast on beat 5 of 8: err_o=1 and IDLE.
  - Separately, rst asserted mid-DATA: all outputs 0 (arid_o/arsize_o/arburst_o at their constants) and IDLE in the same cycle.
